bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-add-3 / double dabble) that produces the
//   per-digit 4-bit codes consumed by the 7-segment display driver. Converts one unsigned
//   binary value per start request into DIGITS BCD nibbles, optionally blanking leading zeros.
//   Sits between the datapath result register and the display driver; done strobes the
//   driver's update enable.
// PARAMETERS
//   IN_W     24  width of unsigned binary input (2^24-1 covers 7 decimal digits)
//   DIGITS   7   number of BCD digits produced (matches the 7 display positions)
//   BLANK_LZ 1   1: digits above the most significant nonzero digit output BLANK_CODE
// PORTS
//   clock     in   1          system clock, all logic on posedge
//   reset_n   in   1          synchronous active-low reset
//   start     in   1          conversion request, sampled only in IDLE
//   bin_in    in   IN_W       unsigned value, captured on the accepting edge
//   busy      out  1          conversion in progress
//   done      out  1          one-cycle pulse: bcd_out/overflow just updated
//   overflow  out  1          last value exceeded 10^DIGITS-1
//   bcd_out   out  4*DIGITS   digit k at [4k+3:4k]; digit 0 = units
// BEHAVIOUR
//   Reset (reset_n=0 at posedge): state=IDLE, busy=0, done=0, overflow=0,
//     every bcd_out nibble = BLANK_CODE (4'hF). Reset mid-conversion aborts; no done issued.
//   FSM: IDLE -> SHIFT -> FINISH -> IDLE.
//   IDLE: start=1 at edge k -> load shift reg {4*DIGITS zeros, bin_in}, cnt=0, ovf_sticky=0,
//     busy=1, go SHIFT. start=0 -> stay; outputs hold.
//   SHIFT: each cycle, every BCD nibble >=5 gets +3 (4-bit, no carry between nibbles), then
//     whole {bcd,bin} reg shifts left 1. Bit leaving bcd MSB ORs into ovf_sticky.
//     cnt increments; after IN_W shifts (edge k+IN_W) go FINISH.
//   FINISH (edge k+IN_W+1): register results, done=1, busy=0, go IDLE.
//     overflow=ovf_sticky. If overflow: all nibbles = BLANK_CODE.
//     Else if BLANK_LZ: nibbles above highest nonzero nibble = BLANK_CODE; digit 0 always
//     shown (value 0 -> ...FFF0).
//   Latency: done high in the cycle after edge k+IN_W+1 (IN_W+1 cycles; 25 at default).
//   start while busy (SHIFT/FINISH) ignored, not queued; bin_in changes during busy ignored.
//   Back-to-back: start sampled high in the done cycle (state IDLE) is accepted.
//   done is never high for more than one cycle; bcd_out/overflow stable between done pulses.
// STRUCTURE
//   Package disp_pkg: BLANK_CODE=4'hF, default DIGITS/IN_W, FSM state enum
//     (ST_IDLE, ST_SHIFT, ST_FINISH).
//   Sub-module bcd_adj3: combinational 4-bit "if >=5 add 3" cell, instantiated DIGITS times.
//   Counter width $clog2(IN_W+1); all other logic in this module.
// TESTING
//   1 reset_n=0 two cycles -> busy=0, done=0, overflow=0, bcd_out=28'hFFFFFFF.
//   2 bin_in=0, start 1 cycle -> done 25 cycles later, bcd_out=28'hFFFFFF0, overflow=0.
//   3 bin_in=1234567 (24'h12D687) -> bcd_out=28'h1234567; then 405 -> 28'hFFFF405;
//     start pulsed with 999 at cycle 5 of busy -> ignored, result stays 405.
//   4 bin_in=9999999 -> bcd_out=28'h9999999, overflow=0; bin_in=10000000 -> overflow=1,
//     bcd_out=28'hFFFFFFF; bin_in=24'hFFFFFF -> overflow=1.
//   5 back-to-back: start held high -> conversions every 26 cycles, done single-cycle each,
//     values 7 then 70 -> 28'hFFFFFF7 then 28'hFFFFF70; BLANK_LZ=0 build -> 28'h0000070.
//   6 reset_n=0 at cycle 10 of a conversion -> no done, outputs at reset values;
//     next start with 42 -> bcd_out=28'hFFFFF42 after 25 cycles.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and FSM state type for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int DEF_IN_W   = 24;
    localparam int DEF_DIGITS = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the datapath result register and the display driver.
interface bin_to_bcd_seq_if import bin_to_bcd_seq_pkg::*; #(
    parameter int IN_W   = DEF_IN_W,
    parameter int DIGITS = DEF_DIGITS
) ();

    logic                  start;
    logic [IN_W-1:0]       bin_in;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start, bin_in,
        input  busy, done, overflow, bcd_out
    );

    modport slave (
        input  start, bin_in,
        output busy, done, overflow, bcd_out
    );

endinterface

// File: rtl/bin_to_bcd_seq_adj3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the next shift.
module bcd_adj3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with overflow detection and optional
// leading-zero blanking; one conversion per accepted start, IN_W+1 cycles of latency.
module bin_to_bcd_seq import bin_to_bcd_seq_pkg::*; #(
    parameter int IN_W     = DEF_IN_W,
    parameter int DIGITS   = DEF_DIGITS,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + IN_W;
    localparam int CNT_W = $clog2(IN_W + 1);

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sreg_q, sreg_d, sreg_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_sticky_q, ovf_sticky_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_blanked;
    logic [DIGITS-1:0]  nz_above;

    assign sreg_adj[IN_W-1:0] = sreg_q[IN_W-1:0];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit = sreg_q[IN_W + 4*gi +: 4];

            bcd_adj3 u_adj3 (
                .nib_i (digit),
                .nib_o (sreg_adj[IN_W + 4*gi +: 4])
            );

            // A digit is "leading" when every digit above it is zero.
            if (gi == DIGITS - 1) begin : g_top
                assign nz_above[gi] = 1'b0;
            end else begin : g_lower
                assign nz_above[gi] = |sreg_q[SR_W-1 : IN_W + 4*(gi+1)];
            end

            assign bcd_blanked[4*gi +: 4] =
                (BLANK_LZ && (gi != 0) && !nz_above[gi] && (digit == 4'd0)) ? BLANK_CODE : digit;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        cnt_d        = cnt_q;
        ovf_sticky_d = ovf_sticky_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q;
        bcd_d        = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sreg_d       = {{BCD_W{1'b0}}, bus.bin_in};
                    cnt_d        = '0;
                    ovf_sticky_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sreg_d       = {sreg_adj[SR_W-2:0], 1'b0};
                ovf_sticky_d = ovf_sticky_q | sreg_adj[SR_W-1];
                cnt_d        = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IN_W - 1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                overflow_d = ovf_sticky_q;
                bcd_d      = ovf_sticky_q ? {DIGITS{BLANK_CODE}} : bcd_blanked;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sreg_q       <= '0;
            cnt_q        <= '0;
            ovf_sticky_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            bcd_q        <= {DIGITS{BLANK_CODE}};
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            ovf_sticky_q <= ovf_sticky_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            bcd_q        <= bcd_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.bcd_out  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed cases plus random conversions, every cycle checked
// against an arithmetic model; a second instance with blanking disabled shares the inputs.
module tb_bin_to_bcd_seq;

    localparam int IN_W   = 24;
    localparam int DIGITS = 7;
    localparam int LAT    = IN_W + 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    bin_to_bcd_seq_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus  ();
    bin_to_bcd_seq_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus0 ();

    assign bus0.start  = bus.start;
    assign bus0.bin_in = bus.bin_in;

    bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS), .BLANK_LZ(1'b1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS), .BLANK_LZ(1'b0)) dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected display word from plain decimal arithmetic.
    function automatic logic [27:0] exp_bcd(input int unsigned v, input bit blank);
        logic [27:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        if (v > 32'd9999999) return 28'hFFFFFFF;
        for (int d = 0; d < DIGITS; d++) begin
            if (blank && d > 0 && v < p) r[4*d +: 4] = 4'hF;
            else                         r[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Model: a request is accepted when idle, results appear LAT edges later.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_ovf  = 1'b0;
    logic [27:0] m_bcd  = 28'hFFFFFFF;
    logic [27:0] m_bcd0 = 28'hFFFFFFF;
    int          m_rem  = 0;
    int unsigned m_val  = 0;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_ovf  = 1'b0;
            m_bcd  = 28'hFFFFFFF;
            m_bcd0 = 28'hFFFFFFF;
            m_rem  = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_ovf  = (m_val > 32'd9999999);
                    m_bcd  = exp_bcd(m_val, 1'b1);
                    m_bcd0 = exp_bcd(m_val, 1'b0);
                end
            end else if (bus.start) begin
                m_busy = 1'b1;
                m_rem  = LAT;
                m_val  = 32'(bus.bin_in);
            end
        end
    end

    always @(negedge clock) begin
        chk("busy",      32'(bus.busy),      32'(m_busy));
        chk("done",      32'(bus.done),      32'(m_done));
        chk("overflow",  32'(bus.overflow),  32'(m_ovf));
        chk("bcd_out",   32'(bus.bcd_out),   32'(m_bcd));
        chk("busy_nb",   32'(bus0.busy),     32'(m_busy));
        chk("done_nb",   32'(bus0.done),     32'(m_done));
        chk("ovf_nb",    32'(bus0.overflow), 32'(m_ovf));
        chk("bcd_nb",    32'(bus0.bcd_out),  32'(m_ovf ? 28'hFFFFFFF : m_bcd0));
        if (bus.done)
            $display("txn value=%0d bcd=%h ovf=%b bcd_noblank=%h",
                     m_val, bus.bcd_out, bus.overflow, bus0.bcd_out);
    end

    task automatic conv(input logic [23:0] v, input int inj, output int lat);
        @(posedge clock); #1;
        bus.start  = 1'b1;
        bus.bin_in = v;
        @(posedge clock); #1;
        bus.start  = 1'b0;
        bus.bin_in = 24'($urandom);
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (inj >= 0 && lat == inj) begin
                bus.start  = 1'b1;
                bus.bin_in = 24'd999;
            end else begin
                bus.start  = 1'b0;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_busy", 32'(bus.busy),     32'd0);
        chk("rst_done", 32'(bus.done),     32'd0);
        chk("rst_ovf",  32'(bus.overflow), 32'd0);
        chk("rst_bcd",  32'(bus.bcd_out),  32'hFFFFFFF);
    endtask

    initial begin
        int lat;
        int n;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        reset_n    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_reset_state();
        reset_n = 1'b1;

        conv(24'd0, -1, lat);
        chk("lat_zero", 32'(lat), 32'(LAT));
        chk("bcd_zero", 32'(bus.bcd_out), 32'hFFFFFF0);
        chk("nb_zero",  32'(bus0.bcd_out), 32'h0000000);
        chk("ovf_zero", 32'(bus.overflow), 32'd0);

        conv(24'h12D687, -1, lat);
        chk("bcd_1234567", 32'(bus.bcd_out), 32'h1234567);

        conv(24'd405, 5, lat);
        chk("lat_405",  32'(lat), 32'(LAT));
        chk("bcd_405",  32'(bus.bcd_out), 32'hFFFF405);
        chk("nb_405",   32'(bus0.bcd_out), 32'h0000405);

        conv(24'd9999999, -1, lat);
        chk("bcd_max",  32'(bus.bcd_out), 32'h9999999);
        chk("ovf_max",  32'(bus.overflow), 32'd0);
        conv(24'd10000000, -1, lat);
        chk("bcd_10m",  32'(bus.bcd_out), 32'hFFFFFFF);
        chk("ovf_10m",  32'(bus.overflow), 32'd1);
        conv(24'hFFFFFF, -1, lat);
        chk("ovf_full", 32'(bus.overflow), 32'd1);

        // Back-to-back with start held high.
        @(posedge clock); #1;
        bus.start  = 1'b1;
        bus.bin_in = 24'd7;
        n = 0;
        while (!bus.done && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        chk("b2b_first", 32'(bus.bcd_out), 32'hFFFFFF7);
        bus.bin_in = 24'd70;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!bus.done && n < 100);
        chk("b2b_period", 32'(n), 32'(LAT + 1));
        chk("b2b_second", 32'(bus.bcd_out), 32'hFFFFF70);
        chk("b2b_nb",     32'(bus0.bcd_out), 32'h0000070);
        bus.start = 1'b0;

        // Reset in the middle of a conversion.
        @(posedge clock); #1;
        bus.start  = 1'b1;
        bus.bin_in = 24'd1234;
        @(posedge clock); #1;
        bus.start  = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_reset_state();
        reset_n = 1'b1;
        conv(24'd42, -1, lat);
        chk("lat_42", 32'(lat), 32'(LAT));
        chk("bcd_42", 32'(bus.bcd_out), 32'hFFFFF42);

        repeat (30) begin
            logic [23:0] v;
            int          inj;
            case ($urandom_range(0, 2))
                0:       v = 24'($urandom_range(0, 9999999));
                1:       v = 24'($urandom);
                default: v = 24'($urandom_range(0, 999));
            endcase
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : -1;
            conv(v, inj, lat);
            chk("lat_rand", 32'(lat), 32'(LAT));
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end

        repeat (3) @(posedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
